// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding, opcodes and defaults.
package muldiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_ERR    = 3'd4,
    ST_ABORT  = 3'd5
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 40;

  // A divide with a zero divisor never reaches the divider; it is trapped at accept.
  function automatic logic is_div_by_zero(input logic op, input logic [31:0] divisor);
    return (op == OP_DIV) && (divisor == 32'd0);
  endfunction

endpackage

// File: rtl/muldiv_watchdog.sv
// Clear/increment watchdog for the sequencer's WAIT state; only used when MULDIV_TIMEOUT_EN is defined.
module muldiv_watchdog
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic incr,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Saturates at the limit so a stalled WAIT cannot wrap back below it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequencer for the shared MULT/DIV resource: accept, launch, wait, write HI/LO, trap errors.
// Optional watchdog/ABORT path is enabled by defining MULDIV_TIMEOUT_EN.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_op,
  input  logic [31:0] opnd_a,
  input  logic [31:0] opnd_b,
  output logic        req_ready,
  output logic        busy,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        mult_start,
  output logic        div_start,
  input  logic        mult_done,
  input  logic        div_done,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        hi_write,
  output logic        lo_write,
  output logic [31:0] hi_data,
  output logic [31:0] lo_data,
  output logic        done,
  output logic        div_zero,
  output logic        timeout
);

  state_t      state;
  state_t      next_state;
  logic        op_q;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        accept;
  logic        capture;
  logic        sel_done;
  logic [31:0] sel_hi;
  logic [31:0] sel_lo;
  logic        wd_expired;

  // Only the launched unit's handshake and results matter; the other unit is ignored.
  assign sel_done = (op_q == OP_MULT) ? mult_done : div_done;
  assign sel_hi   = (op_q == OP_MULT) ? mult_hi   : div_hi;
  assign sel_lo   = (op_q == OP_MULT) ? mult_lo   : div_lo;

`ifdef MULDIV_TIMEOUT_EN
  muldiv_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (state == ST_LAUNCH),
    .incr    (state == ST_WAIT),
    .expired (wd_expired)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // req_ready is exactly "state is IDLE", so a valid request in IDLE is an accept.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (is_div_by_zero(req_op, opnd_b)) begin
            next_state = ST_ERR;
          end else begin
            next_state = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (sel_done) begin
          capture    = 1'b1;
          next_state = ST_WRITE;
        end else if (wd_expired) begin
          next_state = ST_ABORT;
        end
      end
      ST_WRITE, ST_ERR, ST_ABORT: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q   <= OP_MULT;
      unit_a <= '0;
      unit_b <= '0;
    end else if (accept) begin
      op_q   <= req_op;
      unit_a <= opnd_a;
      unit_b <= opnd_b;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      res_hi <= '0;
      res_lo <= '0;
    end else if (capture) begin
      res_hi <= sel_hi;
      res_lo <= sel_lo;
    end
  end

  // All control outputs are decoded from registered state only.
  assign req_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign mult_start = (state == ST_LAUNCH) && (op_q == OP_MULT);
  assign div_start  = (state == ST_LAUNCH) && (op_q == OP_DIV);
  assign hi_write   = (state == ST_WRITE);
  assign lo_write   = (state == ST_WRITE);
  assign done       = (state == ST_WRITE);
  assign hi_data    = (state == ST_WRITE) ? res_hi : 32'd0;
  assign lo_data    = (state == ST_WRITE) ? res_lo : 32'd0;
  assign div_zero   = (state == ST_ERR);

`ifdef MULDIV_TIMEOUT_EN
  assign timeout = (state == ST_ABORT);
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer; timeout checks follow MULDIV_TIMEOUT_EN.
module tb_muldiv_sequencer;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_op;
  logic [31:0] opnd_a;
  logic [31:0] opnd_b;
  logic        req_ready;
  logic        busy;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic        mult_start;
  logic        div_start;
  logic        mult_done;
  logic        div_done;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] hi_data;
  logic [31:0] lo_data;
  logic        done;
  logic        div_zero;
  logic        timeout;

  int vectors;
  int miscompares;
  int wr_cnt;
  int mstart_cnt;
  int dstart_cnt;
  int to_cnt;
  int base_wr;
  int base_ms;
  int base_ds;
  int base_to;

  muldiv_sequencer #(
    .TIMEOUT_CYCLES(40)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .opnd_a     (opnd_a),
    .opnd_b     (opnd_b),
    .req_ready  (req_ready),
    .busy       (busy),
    .unit_a     (unit_a),
    .unit_b     (unit_b),
    .mult_start (mult_start),
    .div_start  (div_start),
    .mult_done  (mult_done),
    .div_done   (div_done),
    .mult_hi    (mult_hi),
    .mult_lo    (mult_lo),
    .div_hi     (div_hi),
    .div_lo     (div_lo),
    .hi_write   (hi_write),
    .lo_write   (lo_write),
    .hi_data    (hi_data),
    .lo_data    (lo_data),
    .done       (done),
    .div_zero   (div_zero),
    .timeout    (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse counters sampled mid-cycle, away from the active edge.
  initial begin
    wr_cnt = 0;
    mstart_cnt = 0;
    dstart_cnt = 0;
    to_cnt = 0;
  end
  always @(negedge clock) begin
    if (hi_write || lo_write) wr_cnt++;
    if (mult_start) mstart_cnt++;
    if (div_start) dstart_cnt++;
    if (timeout) to_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snapshot();
    base_wr = wr_cnt;
    base_ms = mstart_cnt;
    base_ds = dstart_cnt;
    base_to = to_cnt;
  endtask

  // Presents one request for a single edge; returns in the cycle after the accept edge.
  task automatic apply_request(input logic op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_op    = op;
    opnd_a    = a;
    opnd_b    = b;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_op    = 1'b0;
    opnd_a    = '0;
    opnd_b    = '0;
    mult_done = 1'b0;
    div_done  = 1'b0;
    mult_hi   = '0;
    mult_lo   = '0;
    div_hi    = '0;
    div_lo    = '0;

    // Reset values
    #2;
    check_output("rst_req_ready", 32'(req_ready), 32'd1);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_unit_a", unit_a, 32'd0);
    check_output("rst_hi_data", hi_data, 32'd0);
    check_output("rst_pulses", {26'd0, mult_start, div_start, hi_write, done, div_zero, timeout}, 32'd0);
    tick();
    tick();
    #2 reset = 1'b1;
    tick();

    // MULT 7 x -3, mult_done four cycles after mult_start
    snapshot();
    apply_request(1'b0, 32'd7, 32'hFFFFFFFD);
    check_output("mul_launch_start", {30'd0, mult_start, div_start}, 32'b10);
    check_output("mul_launch_busy", {30'd0, busy, req_ready}, 32'b10);
    check_output("mul_unit_b", unit_b, 32'hFFFFFFFD);
    repeat (4) tick();
    check_output("mul_wait_nowrite", 32'(hi_write), 32'd0);
    mult_done = 1'b1;
    mult_hi   = 32'hFFFFFFFF;
    mult_lo   = 32'hFFFFFFEB;
    tick();
    mult_done = 1'b0;
    check_output("mul_write_ctl", {29'd0, hi_write, lo_write, done}, 32'b111);
    check_output("mul_hi_data", hi_data, 32'hFFFFFFFF);
    check_output("mul_lo_data", lo_data, 32'hFFFFFFEB);
    tick();
    check_output("mul_idle_ready", 32'(req_ready), 32'd1);
    check_output("mul_idle_hi_data", hi_data, 32'd0);
    check_output("mul_write_count", 32'(wr_cnt - base_wr), 32'd1);
    check_output("mul_div_start_count", 32'(dstart_cnt - base_ds), 32'd0);

    // DIV 100 / 7 at minimum latency
    snapshot();
    apply_request(1'b1, 32'd100, 32'd7);
    check_output("div_launch_start", {30'd0, mult_start, div_start}, 32'b01);
    tick();
    div_done = 1'b1;
    div_hi   = 32'd2;
    div_lo   = 32'd14;
    tick();
    div_done = 1'b0;
    check_output("div_write_ctl", {30'd0, hi_write, lo_write}, 32'b11);
    check_output("div_hi_data", hi_data, 32'd2);
    check_output("div_lo_data", lo_data, 32'd14);
    tick();
    check_output("div_ready_after", {30'd0, req_ready, hi_write}, 32'b10);

    // Divide by zero trap
    snapshot();
    apply_request(1'b1, 32'd5, 32'd0);
    check_output("dz_pulse", {29'd0, div_zero, busy, req_ready}, 32'b110);
    tick();
    check_output("dz_ready", {30'd0, req_ready, div_zero}, 32'b10);
    check_output("dz_no_start", 32'((dstart_cnt - base_ds) + (mstart_cnt - base_ms)), 32'd0);
    check_output("dz_no_write", 32'(wr_cnt - base_wr), 32'd0);

    // DIV in WAIT ignores mult_done and new requests
    snapshot();
    apply_request(1'b1, 32'd50, 32'd3);
    tick();
    mult_done = 1'b1;
    mult_hi   = 32'hDEAD;
    mult_lo   = 32'hBEEF;
    req_valid = 1'b1;
    req_op    = 1'b0;
    opnd_a    = 32'd9;
    opnd_b    = 32'd9;
    tick();
    mult_done = 1'b0;
    check_output("ign_no_write", 32'(hi_write), 32'd0);
    check_output("ign_unit_a", unit_a, 32'd50);
    check_output("ign_busy", 32'(busy), 32'd1);
    req_valid = 1'b0;
    div_done = 1'b1;
    div_hi   = 32'd2;
    div_lo   = 32'd16;
    tick();
    div_done = 1'b0;
    check_output("ign_hi_data", hi_data, 32'd2);
    check_output("ign_lo_data", lo_data, 32'd16);
    tick();
    check_output("ign_write_count", 32'(wr_cnt - base_wr), 32'd1);
    check_output("ign_mult_start", 32'(mstart_cnt - base_ms), 32'd0);
    check_output("ign_ready", 32'(req_ready), 32'd1);

    // Unit that never finishes
    snapshot();
    apply_request(1'b1, 32'd9, 32'd3);
`ifdef MULDIV_TIMEOUT_EN
    repeat (40) tick();
    check_output("to_not_yet", {30'd0, timeout, busy}, 32'b01);
    tick();
    check_output("to_pulse", {30'd0, timeout, busy}, 32'b11);
    tick();
    check_output("to_ready", {30'd0, req_ready, timeout}, 32'b10);
    check_output("to_count", 32'(to_cnt - base_to), 32'd1);
    check_output("to_no_write", 32'(wr_cnt - base_wr), 32'd0);
    apply_request(1'b1, 32'd20, 32'd4);
    tick();
`else
    repeat (100) tick();
    check_output("hang_busy", 32'(busy), 32'd1);
    check_output("hang_no_timeout", 32'(to_cnt - base_to), 32'd0);
`endif

    // Reset pulled low during WAIT
    snapshot();
    reset = 1'b0;
    #1;
    check_output("rstw_ctl", {29'd0, busy, req_ready, div_start}, 32'b010);
    check_output("rstw_unit_a", unit_a, 32'd0);
    check_output("rstw_data", hi_data | lo_data, 32'd0);
    #2 reset = 1'b1;
    tick();
    div_done = 1'b1;
    div_hi   = 32'h55;
    div_lo   = 32'h66;
    tick();
    tick();
    div_done = 1'b0;
    check_output("rstw_ready", 32'(req_ready), 32'd1);
    check_output("rstw_no_write", 32'(wr_cnt - base_wr), 32'd0);

    // Normal operation resumes after reset
    apply_request(1'b0, 32'h10000, 32'h10000);
    tick();
    mult_done = 1'b1;
    mult_hi   = 32'd1;
    mult_lo   = 32'd0;
    tick();
    mult_done = 1'b0;
    check_output("post_rst_hi", hi_data, 32'd1);
    check_output("post_rst_done", 32'(done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
